tlp_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the AXI4 write path (AW + W channels) into the TLP generator's AXI4 decoding stage between `NUM_REQ` AXI4 write requesters. It grants one requester per burst, forwards that burst's single AW transfer and then all of its W beats, and holds the grant until the beat carrying `wlast` is accepted. It also counts beats against `awlen` and flags protocol mismatches. It sits between the AXI4 write masters (DMA engines) and the AXI4 decoding block that produces decoding results for TLP build.

---
 rtl/tlp_wr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_tlp_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_wr_arbiter.sv
// tlp_wr_arbiter
// Round-robin arbiter sharing the AXI4 write path (AW + W) between NUM_REQ
// write requesters in front of the TLP generator's AXI4 decoding stage.
// One requester is granted per burst. Its AW transfer is forwarded, then its
// W beats. The grant is held until the wlast beat is accepted. Beats are
// counted against awlen, and any mismatch raises a sticky len_err.
// Optional build macro: TLP_WR_ARB_ID_TAG_EN. When it is defined, m_awid
// carries {grant_idx, awid} so completions can be routed back per requester.
module tlp_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
`ifdef TLP_WR_ARB_ID_TAG_EN
  localparam int M_ID_W    = ID_WIDTH + IDX_W
`else
  localparam int M_ID_W    = ID_WIDTH
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // requester side
  input  logic [NUM_REQ-1:0]               s_awvalid,
  output logic [NUM_REQ-1:0]               s_awready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]      s_awid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_awaddr,
  input  logic [NUM_REQ*8-1:0]             s_awlen,
  input  logic [NUM_REQ-1:0]               s_wvalid,
  output logic [NUM_REQ-1:0]               s_wready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_wdata,
  input  logic [NUM_REQ-1:0]               s_wlast,
  // decoder side
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [M_ID_W-1:0]                m_awid,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [7:0]                       m_awlen,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic                             m_wlast,
  // status
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             busy,
  output logic                             len_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [7:0]         beat_left_reg, beat_left_next;
  logic               len_err_reg, len_err_next;

  // Unpacked views of the packed per-requester buses
  logic [ID_WIDTH-1:0]   awid_arr   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] awaddr_arr [NUM_REQ];
  logic [7:0]            awlen_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr  [NUM_REQ];

  logic               in_addr, in_data;
  logic               g_awvalid, g_wvalid, g_wlast;
  logic               aw_hs, w_hs;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign awid_arr[gi]   = s_awid[gi*ID_WIDTH +: ID_WIDTH];
      assign awaddr_arr[gi] = s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign awlen_arr[gi]  = s_awlen[gi*8 +: 8];
      assign wdata_arr[gi]  = s_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      // Only the granted requester ever sees ready, and only in its phase
      assign s_awready[gi]  = in_addr && (grant_reg == IDX_W'(gi)) && m_awready;
      assign s_wready[gi]   = in_data && (grant_reg == IDX_W'(gi)) && m_wready;
    end
  endgenerate

  assign in_addr   = (state_reg == ST_ADDR);
  assign in_data   = (state_reg == ST_DATA);

  assign g_awvalid = s_awvalid[grant_reg];
  assign g_wvalid  = s_wvalid[grant_reg];
  assign g_wlast   = s_wlast[grant_reg];

  // Zero-cycle pass-through of the granted requester; valids gated by phase
  assign m_awvalid = in_addr && g_awvalid;
  assign m_awaddr  = awaddr_arr[grant_reg];
  assign m_awlen   = awlen_arr[grant_reg];
  assign m_wvalid  = in_data && g_wvalid;
  assign m_wdata   = wdata_arr[grant_reg];
  assign m_wlast   = g_wlast;
`ifdef TLP_WR_ARB_ID_TAG_EN
  assign m_awid    = {grant_reg, awid_arr[grant_reg]};
`else
  assign m_awid    = awid_arr[grant_reg];
`endif

  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;

  assign grant_idx = grant_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign len_err   = len_err_reg;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!arb_found && s_awvalid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: grant, address phase, beat counting and length check
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_left_next = beat_left_reg;
    len_err_next   = len_err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arb_found) begin
          grant_next = arb_idx;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // A requester that drops awvalid here simply holds the FSM
        if (aw_hs) begin
          beat_left_next = m_awlen;
          state_next     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          // Early last (beats remain) or late last (count already exhausted)
          if (g_wlast && (beat_left_reg != 8'd0)) begin
            len_err_next = 1'b1;
          end
          if (!g_wlast && (beat_left_reg == 8'd0)) begin
            len_err_next = 1'b1;
          end
          // Saturate at zero so an overlong burst keeps running until wlast
          if (beat_left_reg != 8'd0) begin
            beat_left_next = beat_left_reg - 8'd1;
          end
          if (g_wlast) begin
            state_next  = ST_IDLE;
            rr_ptr_next = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0
                                                            : grant_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      beat_left_reg <= 8'd0;
      len_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_left_reg <= beat_left_next;
      len_err_reg   <= len_err_next;
    end
  end

endmodule

// File: tb/tb_tlp_wr_arbiter.sv
// Testbench for tlp_wr_arbiter (NUM_REQ=2). Table of per-cycle vectors plus
// hand-written sequences for length errors and reset in the middle of a burst.
module tb_tlp_wr_arbiter;

  localparam int NR  = 2;
  localparam int IW  = 4;
  localparam int AW  = 32;
  localparam int DW  = 256;
`ifdef TLP_WR_ARB_ID_TAG_EN
  localparam int MIW = IW + 1;
`else
  localparam int MIW = IW;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NR-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [NR*IW-1:0]   s_awid;
  logic [NR*AW-1:0]   s_awaddr;
  logic [NR*8-1:0]    s_awlen;
  logic [NR*DW-1:0]   s_wdata;
  logic               m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [MIW-1:0]     m_awid;
  logic [AW-1:0]      m_awaddr;
  logic [7:0]         m_awlen;
  logic [DW-1:0]      m_wdata;
  logic               grant_idx;
  logic               busy, len_err;

  int n_checks = 0;
  int n_fail   = 0;

  tlp_wr_arbiter #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .grant_idx(grant_idx), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] awv;  logic [7:0] al0;  logic [7:0] al1;
    logic [1:0] wv;   logic [1:0] wl;   logic [7:0] wd0;  logic [7:0] wd1;
    logic       mar;  logic       mwr;
    logic       emav; logic       emwv; logic [7:0] ewd;  logic ewl;
    logic [1:0] esar; logic [1:0] eswr; logic eg; logic ebusy; logic elerr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] awv, input logic [7:0] al0, input logic [7:0] al1,
                       input logic [1:0] wv, input logic [1:0] wl,
                       input logic [7:0] wd0, input logic [7:0] wd1,
                       input logic mar, input logic mwr);
    s_awvalid = awv;
    s_awlen   = {al1, al0};
    s_wvalid  = wv;
    s_wlast   = wl;
    s_wdata   = '0;
    s_wdata[7:0]       = wd0;
    s_wdata[DW+7:DW]   = wd1;
    m_awready = mar;
    m_wready  = mwr;
  endtask

  function automatic logic [MIW-1:0] exp_awid(input logic g);
    logic [IW-1:0] id;
    id = g ? 4'h5 : 4'h3;
`ifdef TLP_WR_ARB_ID_TAG_EN
    return {g, id};
`else
    return id;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " m_awvalid"}, 256'(m_awvalid), 256'(0));
    check({tag, " m_wvalid"},  256'(m_wvalid),  256'(0));
    check({tag, " s_awready"}, 256'(s_awready), 256'(0));
    check({tag, " s_wready"},  256'(s_wready),  256'(0));
    check({tag, " grant_idx"}, 256'(grant_idx), 256'(0));
    check({tag, " busy"},      256'(busy),      256'(0));
    check({tag, " len_err"},   256'(len_err),   256'(0));
  endtask

  initial begin
    s_awid   = {4'h5, 4'h3};
    s_awaddr = {32'h0000_2000, 32'h0000_1000};
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);

    // awv al0 al1 wv wl wd0 wd1 mar mwr | emav emwv ewd ewl esar eswr eg ebusy elerr
    // Contention: both request, req0 first, then req1 wins the next pair
    tbl.push_back(vec_t'{2'b11, 8'd1, 8'd1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{2'b11, 8'd1, 8'd1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd1, 8'd1, 2'b11, 2'b00, 8'h20, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd1, 8'd1, 2'b11, 2'b11, 8'h21, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b11, 8'd1, 8'd1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{2'b11, 8'd1, 8'd1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b01, 8'd1, 8'd1, 2'b11, 2'b00, 8'h77, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b01, 8'd1, 8'd1, 2'b11, 2'b11, 8'h77, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 8'h31, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0});
    // req0 awaddr 0x1000 awlen 3; AW stalled once, early W held back, m_wready toggling
    tbl.push_back(vec_t'{2'b11, 8'd3, 8'd1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{2'b11, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b11, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b00, 8'hA2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b01, 8'hA3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b10, 8'd3, 8'd1, 2'b01, 2'b01, 8'hA3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0});
    // Pointer now at req1; req1 awlen 3 with wlast on beat 2 (early last)
    tbl.push_back(vec_t'{2'b11, 8'd1, 8'd3, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{2'b11, 8'd1, 8'd3, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b01, 8'd1, 8'd3, 2'b10, 2'b00, 8'h00, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b01, 8'd1, 8'd3, 2'b10, 2'b10, 8'h00, 8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{2'b00, 8'd1, 8'd3, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven section: drive at negedge, sample 1 time unit later
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].awv, tbl[i].al0, tbl[i].al1, tbl[i].wv, tbl[i].wl,
            tbl[i].wd0, tbl[i].wd1, tbl[i].mar, tbl[i].mwr);
      #1;
      check($sformatf("row%0d m_awvalid", i), 256'(m_awvalid), 256'(tbl[i].emav));
      check($sformatf("row%0d m_wvalid", i),  256'(m_wvalid),  256'(tbl[i].emwv));
      check($sformatf("row%0d s_awready", i), 256'(s_awready), 256'(tbl[i].esar));
      check($sformatf("row%0d s_wready", i),  256'(s_wready),  256'(tbl[i].eswr));
      check($sformatf("row%0d grant_idx", i), 256'(grant_idx), 256'(tbl[i].eg));
      check($sformatf("row%0d busy", i),      256'(busy),      256'(tbl[i].ebusy));
      check($sformatf("row%0d len_err", i),   256'(len_err),   256'(tbl[i].elerr));
      if (tbl[i].emav) begin
        check($sformatf("row%0d m_awaddr", i), 256'(m_awaddr),
              256'(tbl[i].eg ? 32'h2000 : 32'h1000));
        check($sformatf("row%0d m_awlen", i), 256'(m_awlen),
              256'(tbl[i].eg ? tbl[i].al1 : tbl[i].al0));
        check($sformatf("row%0d m_awid", i), 256'(m_awid), 256'(exp_awid(tbl[i].eg)));
      end
      if (tbl[i].emwv) begin
        check($sformatf("row%0d m_wdata", i), 256'(m_wdata), 256'(tbl[i].ewd));
        check($sformatf("row%0d m_wlast", i), 256'(m_wlast), 256'(tbl[i].ewl));
      end
      $display("row %0d: awv=%b wv=%b wl=%b mar=%b mwr=%b -> grant=%0d busy=%b len_err=%b",
               i, tbl[i].awv, tbl[i].wv, tbl[i].wl, tbl[i].mar, tbl[i].mwr,
               grant_idx, busy, len_err);
    end

    // Late last: after reset, req0 awlen 0 sends two beats
    @(negedge clk);
    rst_n = 1'b0;
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    check_reset_outputs("late_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 8'd0, 8'd0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b01, 8'd0, 8'd0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
    #1;
    check("late awlen", 256'(m_awlen), 256'(0));
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 8'hB0, 8'h00, 1'b0, 1'b1);
    #1;
    check("late beat1 wvalid", 256'(m_wvalid), 256'(1));
    check("late beat1 wdata",  256'(m_wdata),  256'(8'hB0));
    check("late beat1 len_err", 256'(len_err), 256'(0));
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd0, 2'b01, 2'b01, 8'hB1, 8'h00, 1'b0, 1'b1);
    #1;
    check("late len_err set", 256'(len_err),   256'(1));
    check("late beat2 wvalid", 256'(m_wvalid), 256'(1));
    check("late beat2 wdata",  256'(m_wdata),  256'(8'hB1));
    check("late beat2 wlast",  256'(m_wlast),  256'(1));
    $display("late-last: two beats forwarded, len_err=%b", len_err);
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    check("late done busy",    256'(busy),    256'(0));
    check("late done len_err", 256'(len_err), 256'(1));

    // Reset mid-DATA: req1 awlen 3, reset after beat 1
    @(negedge clk);
    drive(2'b10, 8'd0, 8'd3, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b10, 8'd0, 8'd3, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
    #1;
    check("mid grant", 256'(grant_idx), 256'(1));
    @(negedge clk);
    drive(2'b00, 8'd0, 8'd3, 2'b10, 2'b00, 8'h00, 8'hC0, 1'b1, 1'b1);
    @(negedge clk);
    drive(2'b11, 8'd0, 8'd3, 2'b10, 2'b00, 8'h00, 8'hC1, 1'b1, 1'b1);
    #1;
    check("mid beat2 wvalid", 256'(m_wvalid), 256'(1));
    check("mid beat2 wready", 256'(s_wready), 256'(2'b10));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    $display("reset mid-burst: m_wvalid=%b s_wready=%b busy=%b", m_wvalid, s_wready, busy);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 8'd0, 8'd3, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("post_rst grant",  256'(grant_idx), 256'(0));
    check("post_rst awvalid", 256'(m_awvalid), 256'(1));
    check("post_rst awaddr", 256'(m_awaddr),  256'(32'h1000));
    check("post_rst awid",   256'(m_awid),    256'(exp_awid(1'b0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
